ser_rx_fifo: RTL and testbench
==============================

# ser_rx_fifo

Parametrised single-clock serial flit receiver for router input ports. It deserialises flits arriving on LANES parallel serial wires, each framed by a start beat and a parity/stop beat. Good flits are buffered in a DEPTH-entry FIFO, which the router input stage drains with a valid/item_read handshake. Parity-failed flits are dropped and counted, and `channel_busy` gives back-pressure to the upstream serialiser.

## Interface
- `DATA_W`, default 16: flit width in bits (HDR+PL+ADDR); must be a multiple of LANES.
- `LANES`, default 1: serial lanes; allowed values 1, 2, 4 or 8.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `port`, default "unknown": port label; simulation messages only.
- `clk  in  1`: sole clock; all logic on its rising edge.
- `reset  in  1`: asynchronous, active-high; clears all state immediately.
- `serial_in  in  LANES`: serial data; lane i carries bit beat*LANES+i.
- `item_read  in  1`: pops the FIFO head when `valid`=1; ignored when `valid`=0.
- `valid  out  1`: FIFO non-empty.
- `parallel_out  out  DATA_W`: FIFO head entry; 0 when empty.
- `channel_busy  out  1`: upstream must not send a start beat while high.
- `perr  out  1`: one-cycle pulse, parity failure, flit dropped.
- `ovf  out  1`: one-cycle pulse, start beat seen while FIFO full, ignored.
- `err_count  out  8`: saturating count of `perr` plus `ovf` events.

## Operation
- N = DATA_W/LANES data beats per flit. Frame: start beat, then N data beats (LSB group first), then stop beat.
- Start beat: `serial_in[0]`=1 in IDLE. Other lanes in the start beat are don't-care.
- Stop beat: `serial_in[0]` = XOR of all DATA_W bits (even parity). Other lanes are don't-care.
- States:
  - IDLE: on a start beat with FIFO not full, go to DATA and clear the beat counter. On a start beat with FIFO full, stay in IDLE and pulse `ovf`.
  - DATA: shift in LANES bits per cycle. After beat N-1, go to STOP.
  - STOP: check parity. On pass, push the assembled flit; on fail, pulse `perr` and discard. Return to IDLE.
- Beat counter width: clog2(N), minimum 1 bit. The shift register is exactly DATA_W wide; no sentinel bit.
- `channel_busy` = (state≠IDLE) OR (count==DEPTH). It is combinational from registers only, with no path from `serial_in`.
- FIFO:
  - Read/write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - Count is clog2(DEPTH)+1 bits.
  - Overflow cannot occur, because a start beat is accepted only when count<DEPTH and at most one flit is in flight.
- Simultaneous push and pop (STOP with a good flit, plus `item_read` with `valid`=1): both occur, count is unchanged, and the pointers both advance.
- Push into an empty FIFO: `parallel_out` shows the new flit the next cycle.
- `err_count` saturates at 255. `perr` and `ovf` cannot coincide.

## Timing
- Reset values: state IDLE, FIFO empty, `valid`=0, `parallel_out`=0, `channel_busy`=0, `perr`=0, `ovf`=0, `err_count`=0.
- With the start beat sampled at edge 0:
  - Data beats are sampled at edges 1..N and the stop beat at edge N+1.
  - `channel_busy` rises after edge 0.
  - `valid` rises after edge N+1, if the FIFO was empty.
  - `perr` is high for the cycle after edge N+1.
- Latency from start beat to `valid` is N+2 cycles.
- Back-to-back frames: a new start beat may arrive the cycle immediately after the stop beat, provided `channel_busy` is low then.
- `item_read` pops at the edge where it is sampled high with `valid`=1. The next entry appears the following cycle, or `valid` drops if that was the last entry.
- Reset mid-frame: the partial flit is discarded and the FIFO is emptied. After reset releases, the first `serial_in[0]`=1 is treated as a start beat.

## Test plan
- LANES=1, DATA_W=16: send 0xA5C3 (16 data beats, stop=0) -> `valid` rises 18 cycles after the start beat; `parallel_out`=0xA5C3; `perr`=0.
- LANES=4: send 0x1234 (4 data beats, stop=1) -> `valid` after 6 cycles; `parallel_out`=0x1234; a single `item_read` pulse returns `valid` to 0.
- Parity error: send 0xA5C3 with stop=1 -> no push; `perr` pulses once; `err_count`=1; `channel_busy` falls the cycle after the stop beat.
- DEPTH=4, no reads: send 4 good flits back-to-back, then a 5th start beat:
  - Required: `channel_busy` stays high after the 4th push; `ovf` pulses; `err_count` increments.
  - Required: draining returns the 4 flits in order and `channel_busy` drops after the first pop.
- FIFO holding 2 entries: pulse `item_read` in the same cycle as the stop beat of a good flit -> count stays 2; order is preserved; pointer wrap is exercised over 10 flits.
- Assert `reset` for 1 cycle halfway through a frame -> all outputs return to reset values immediately; the next full frame is received correctly.

Source files
------------

// File: rtl/ser_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ser_rx_fifo
// Brief   : Framed multi-lane serial flit receiver with even-parity check and
//           a DEPTH-entry FIFO drained by a valid/item_read handshake.
// Rev     : 1.0
// ============================================================================
module ser_rx_fifo #(
    parameter int DATA_W = 16,
    parameter int LANES  = 1,
    parameter int DEPTH  = 4,
    parameter     port   = "unknown"
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LANES-1:0]  serial_in,
    input  logic              item_read,
    output logic              valid,
    output logic [DATA_W-1:0] parallel_out,
    output logic              channel_busy,
    output logic              perr,
    output logic              ovf,
    output logic [7:0]        err_count
);

    localparam int c_BEATS = DATA_W / LANES;
    localparam int c_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);
    localparam logic [c_PTR_W:0]   c_FULL      = (c_PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_beat;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W:0]    r_count;
    logic                r_perr;
    logic                r_ovf;
    logic [7:0]          r_err_count;

    logic [DATA_W-1:0]   w_shift_next;
    logic                w_full;
    logic                w_parity_ok;
    logic                w_push;
    logic                w_pop;
    logic                w_err_event;
    logic                w_unused_port;

    // Label exists only for simulation messages; keep it referenced.
    assign w_unused_port = ^port;

    // Later beats enter at the top so the first beat ends up in the LSBs.
    generate
        if (c_BEATS == 1) begin : g_single_beat
            assign w_shift_next = serial_in;
        end else begin : g_multi_beat
            assign w_shift_next = {serial_in, r_shift[DATA_W-1:LANES]};
        end
    endgenerate

    assign w_full      = (r_count == c_FULL);
    assign w_parity_ok = ((^r_shift) == serial_in[0]);
    assign w_push      = (r_state == S_STOP) && w_parity_ok;
    assign w_pop       = item_read && valid;
    assign w_err_event = ((r_state == S_IDLE) && serial_in[0] && w_full) ||
                         ((r_state == S_STOP) && !w_parity_ok);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_shift     <= '0;
            r_perr      <= 1'b0;
            r_ovf       <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_perr <= 1'b0;
            r_ovf  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (serial_in[0]) begin
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                            r_beat  <= '0;
                        end
                    end
                end
                S_DATA: begin
                    r_shift <= w_shift_next;
                    r_beat  <= r_beat + 1'b1;
                    if (r_beat == c_LAST_BEAT) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_perr  <= !w_parity_ok;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_err_event && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    assign valid        = (r_count != '0);
    assign parallel_out = valid ? r_mem[r_rd_ptr] : '0;
    assign channel_busy = (r_state != S_IDLE) || w_full;
    assign perr         = r_perr;
    assign ovf          = r_ovf;
    assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_ser_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_ser_rx_fifo
// Brief   : Randomized frame traffic for ser_rx_fifo against a queue model.
// Rev     : 1.0
// ============================================================================
module tb_ser_rx_fifo;

    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int DEPTH  = 4;
    localparam int N      = DATA_W / LANES;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [LANES-1:0]  serial_in = '0;
    logic              item_read = 1'b0;
    logic              valid;
    logic [DATA_W-1:0] parallel_out;
    logic              channel_busy;
    logic              perr;
    logic              ovf;
    logic [7:0]        err_count;

    ser_rx_fifo #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .port   ("tb")
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .item_read    (item_read),
        .valid        (valid),
        .parallel_out (parallel_out),
        .channel_busy (channel_busy),
        .perr         (perr),
        .ovf          (ovf),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    int                n_vec  = 0;
    int                n_miss = 0;

    // Model: queue of accepted flits plus the sender's position in its frame.
    logic [DATA_W-1:0] q[$];
    int                tx_beat = -1;
    logic [DATA_W-1:0] tx_flit = '0;
    bit                tx_bad = 1'b0;
    bit                exp_perr = 1'b0;
    bit                exp_ovf = 1'b0;
    int                exp_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("valid", 32'(valid), 32'(q.size() > 0));
        check("parallel_out", 32'(parallel_out), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        check("channel_busy", 32'(channel_busy), 32'((tx_beat >= 0) || (q.size() == DEPTH)));
        check("perr", 32'(perr), 32'(exp_perr));
        check("ovf", 32'(ovf), 32'(exp_ovf));
        check("err_count", 32'(err_count), 32'(exp_err));
    endtask

    task automatic model_reset();
        q.delete();
        tx_beat  = -1;
        exp_perr = 1'b0;
        exp_ovf  = 1'b0;
        exp_err  = 0;
    endtask

    // One clock: check the previous edge's result, then drive and predict the next edge.
    task automatic step(input int rd_pct, input int start_pct, input int bad_pct);
        logic [LANES-1:0] si;
        logic             rd;
        bit               push;
        @(negedge clk);
        check_outputs();
        si       = LANES'($urandom());
        push     = 1'b0;
        exp_perr = 1'b0;
        exp_ovf  = 1'b0;
        if (tx_beat < 0) begin
            si[0] = 1'b0;
            if (int'($urandom_range(99)) < start_pct) begin
                si[0] = 1'b1;
                if (q.size() < DEPTH) begin
                    tx_flit = DATA_W'($urandom());
                    tx_bad  = (int'($urandom_range(99)) < bad_pct);
                    tx_beat = 0;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end else if (tx_beat < N) begin
            si = tx_flit[tx_beat*LANES +: LANES];
            tx_beat++;
        end else begin
            si[0] = (^tx_flit) ^ tx_bad;
            if (tx_bad) exp_perr = 1'b1;
            else        push     = 1'b1;
            tx_beat = -1;
        end
        rd        = (int'($urandom_range(99)) < rd_pct);
        serial_in = si;
        item_read = rd;
        if (rd && (q.size() > 0)) void'(q.pop_front());
        if (push) q.push_back(tx_flit);
        if ((exp_perr || exp_ovf) && (exp_err < 255)) exp_err++;
    endtask

    task automatic mid_frame_reset();
        int guard = 0;
        while ((tx_beat < 2) && (guard < 200)) begin
            step(50, 100, 0);
            guard++;
        end
        check("reset_frame_reached", 32'(tx_beat >= 2), 32'd1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset     = 1'b0;
        serial_in = '0;
        item_read = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b0;
        repeat (300) step(50, 60, 20);
        repeat (500) step(0, 70, 10);
        repeat (300) step(100, 80, 10);
        mid_frame_reset();
        repeat (300) step(40, 90, 15);
        mid_frame_reset();
        repeat (300) step(60, 50, 20);
        @(negedge clk);
        check_outputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
